// File: rtl/adder_reduction_acc_seq_pkg.sv
// Shared reduction-tree helpers: constant clog2, widened output width, and
// the group-collection state encoding.
package adder_reduction_acc_seq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_t;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

  // Summing na values of (dw+1) bits needs clog2(na) guard bits to never overflow.
  function automatic int out_width(input int dw, input int na);
    return dw + 1 + clog2(na);
  endfunction

endpackage

// File: rtl/adder_reduction_acc_seq.sv
// Sums each consecutive group of NUM_ACC valid adder results and emits one
// widened, registered total per group.
module adder_reduction_acc_seq
  import adder_reduction_acc_seq_pkg::*;
#(
  parameter int  DATA_WIDTH = 16,
  parameter int  NUM_ACC    = 4,
  localparam int CNT_WIDTH  = clog2(NUM_ACC),
  localparam int OUT_WIDTH  = out_width(DATA_WIDTH, NUM_ACC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH:0]   i_data_bus,
  input  logic                  i_en,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [OUT_WIDTH-1:0]  o_data_bus,
  output logic                  o_busy
);

  if ((NUM_ACC < 2) || (NUM_ACC > 256)) begin : g_bad_num_acc
    $error("adder_reduction_acc_seq: NUM_ACC must be in 2..256");
  end

  localparam logic [CNT_WIDTH-1:0] C_CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_LAST = CNT_WIDTH'(NUM_ACC - 1);

  acc_state_t             r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [OUT_WIDTH-1:0]   r_acc;
  logic                   r_valid;
  logic [OUT_WIDTH-1:0]   r_data;
  logic                   r_busy;

  acc_state_t             w_state_nxt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic [OUT_WIDTH-1:0]   w_acc_nxt;
  logic                   w_valid_nxt;
  logic [OUT_WIDTH-1:0]   w_data_nxt;
  logic [OUT_WIDTH-1:0]   w_din_ext;
  logic [OUT_WIDTH-1:0]   w_sum;

  assign w_din_ext = OUT_WIDTH'(i_data_bus);
  assign w_sum     = r_acc + w_din_ext;

  // Next-state, counter, accumulator and output-total selection.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_valid_nxt = 1'b0;
    w_data_nxt  = {OUT_WIDTH{1'bx}};
    if (i_en) begin
      if (i_flush) begin
        // Flush discards the partial group; a same-cycle sample opens a new one.
        if (i_valid) begin
          w_acc_nxt = w_din_ext;
          w_cnt_nxt = C_CNT_ONE;
        end else begin
          w_cnt_nxt = C_CNT_ZERO;
        end
      end else if (i_valid) begin
        case (r_state)
          ST_IDLE: begin
            w_acc_nxt = w_din_ext;
            w_cnt_nxt = C_CNT_ONE;
          end
          ST_ACCUM: begin
            if (r_cnt == C_CNT_LAST) begin
              w_data_nxt  = w_sum;
              w_valid_nxt = 1'b1;
              w_cnt_nxt   = C_CNT_ZERO;
            end else begin
              w_acc_nxt = w_sum;
              w_cnt_nxt = r_cnt + C_CNT_ONE;
            end
          end
          default: begin
            w_cnt_nxt = C_CNT_ZERO;
          end
        endcase
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
    if (w_cnt_nxt == C_CNT_ZERO) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = ST_ACCUM;
    end
  end

  // Control state resets; the accumulator and total are datapath-only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= C_CNT_ZERO;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= (w_state_nxt == ST_ACCUM);
    end
  end

  // Accumulator and group total registers.
  always_ff @(posedge clk) begin
    r_acc  <= w_acc_nxt;
    r_data <= w_data_nxt;
  end

  assign o_valid    = r_valid;
  assign o_data_bus = r_data;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_adder_reduction_acc_seq.sv
// Directed bench for adder_reduction_acc_seq (DATA_WIDTH=16, NUM_ACC=4).
module tb_adder_reduction_acc_seq;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [16:0] i_data_bus;
  logic        i_en;
  logic        i_flush;
  logic        o_valid;
  logic [18:0] o_data_bus;
  logic        o_busy;

  int checks;
  int errors;

  adder_reduction_acc_seq #(
    .DATA_WIDTH(16),
    .NUM_ACC   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_data_bus(i_data_bus),
    .i_en      (i_en),
    .i_flush   (i_flush),
    .o_valid   (o_valid),
    .o_data_bus(o_data_bus),
    .o_busy    (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [16:0] d, input logic en, input logic fl);
    i_valid    = v;
    i_data_bus = d;
    i_en       = en;
    i_flush    = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 17'd7, 1'b1, 1'b0);
    step();
    step();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", o_valid);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", o_busy);
    end
    rst = 1'b0;
    drive(1'b0, 17'd0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 17'(i + 1), 1'b1, 1'b0);
      step();
      checks++;
      if (o_busy !== (i != 3)) begin
        errors++;
        $display("FAIL basic_busy step %0d got %b want %b", i, o_busy, (i != 3));
      end
      checks++;
      if (o_valid !== (i == 3)) begin
        errors++;
        $display("FAIL basic_valid step %0d got %b want %b", i, o_valid, (i == 3));
      end
    end
    checks++;
    if (o_data_bus !== 19'd10) begin
      errors++;
      $display("FAIL basic_total got %0d want 10", o_data_bus);
    end
    drive(1'b0, 17'd0, 1'b1, 1'b0);
    step();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse_width got %b want 0", o_valid);
    end
  endtask

  task automatic test_max();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 17'h1FFFF, 1'b1, 1'b0);
      step();
    end
    checks++;
    if ((o_valid !== 1'b1) || (o_data_bus !== 19'h7FFFC)) begin
      errors++;
      $display("FAIL max_total got v=%b %h want v=1 7fffc", o_valid, o_data_bus);
    end
    drive(1'b0, 17'd0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    logic        bv [12];
    logic [16:0] bd [12];
    int          k;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 17'(i + 1), 1'b1, 1'b0);
      step();
      checks++;
      if (o_valid !== ((i == 3) || (i == 7))) begin
        errors++;
        $display("FAIL b2b_valid step %0d got %b", i, o_valid);
      end
      if (i == 3) begin
        checks++;
        if (o_data_bus !== 19'd10) begin
          errors++;
          $display("FAIL b2b_total0 got %0d want 10", o_data_bus);
        end
      end
      if (i == 7) begin
        checks++;
        if (o_data_bus !== 19'd26) begin
          errors++;
          $display("FAIL b2b_total1 got %0d want 26", o_data_bus);
        end
      end
    end
    // Same stream with bubbles: 1 _ 2 3 _ _ 4 5 6 _ 7 8
    bv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bd = '{17'd1, 17'd99, 17'd2, 17'd3, 17'd99, 17'd99, 17'd4, 17'd5, 17'd6, 17'd99, 17'd7, 17'd8};
    k = 0;
    for (int i = 0; i < 12; i++) begin
      drive(bv[i], bd[i], 1'b1, 1'b0);
      step();
      if (bv[i]) k++;
      checks++;
      if (o_valid !== (bv[i] && ((k == 4) || (k == 8)))) begin
        errors++;
        $display("FAIL bubble_valid step %0d got %b", i, o_valid);
      end
      if (bv[i] && (k == 4)) begin
        checks++;
        if (o_data_bus !== 19'd10) begin
          errors++;
          $display("FAIL bubble_total0 got %0d want 10", o_data_bus);
        end
      end
      if (bv[i] && (k == 8)) begin
        checks++;
        if (o_data_bus !== 19'd26) begin
          errors++;
          $display("FAIL bubble_total1 got %0d want 26", o_data_bus);
        end
      end
    end
    drive(1'b0, 17'd0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_flush();
    logic [16:0] fd [6];
    logic        ff [6];
    fd = '{17'd5, 17'd6, 17'd7, 17'd1, 17'd1, 17'd1};
    ff = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, fd[i], 1'b1, ff[i]);
      step();
      checks++;
      if (o_valid !== (i == 5)) begin
        errors++;
        $display("FAIL flush_valid step %0d got %b want %b", i, o_valid, (i == 5));
      end
    end
    checks++;
    if (o_data_bus !== 19'd10) begin
      errors++;
      $display("FAIL flush_total got %0d want 10", o_data_bus);
    end
    drive(1'b1, 17'd2, 1'b1, 1'b0);
    step();
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_busy got %b want 1", o_busy);
    end
    drive(1'b0, 17'd0, 1'b1, 1'b1);
    step();
    checks++;
    if ((o_busy !== 1'b0) || (o_valid !== 1'b0)) begin
      errors++;
      $display("FAIL flush_idle got busy=%b valid=%b want 0 0", o_busy, o_valid);
    end
    // Flush while disabled is ignored: group 1 + (flush) + 2,3,4 totals 10.
    drive(1'b1, 17'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 17'd50, 1'b0, 1'b1);
    step();
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_disabled_busy got %b want 1", o_busy);
    end
    for (int i = 2; i <= 4; i++) begin
      drive(1'b1, 17'(i), 1'b1, 1'b0);
      step();
    end
    checks++;
    if ((o_valid !== 1'b1) || (o_data_bus !== 19'd10)) begin
      errors++;
      $display("FAIL flush_disabled_total got v=%b %0d want v=1 10", o_valid, o_data_bus);
    end
    drive(1'b0, 17'd0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_enable_freeze();
    drive(1'b1, 17'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 17'd2, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 17'd100, 1'b0, 1'b0);
      step();
      checks++;
      if ((o_valid !== 1'b0) || (o_busy !== 1'b1)) begin
        errors++;
        $display("FAIL freeze_window %0d got valid=%b busy=%b want 0 1", i, o_valid, o_busy);
      end
    end
    drive(1'b1, 17'd3, 1'b1, 1'b0);
    step();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL freeze_early got %b want 0", o_valid);
    end
    drive(1'b1, 17'd4, 1'b1, 1'b0);
    step();
    checks++;
    if ((o_valid !== 1'b1) || (o_data_bus !== 19'd10)) begin
      errors++;
      $display("FAIL freeze_total got v=%b %0d want v=1 10", o_valid, o_data_bus);
    end
    drive(1'b0, 17'd0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 17'd9, 1'b1, 1'b0);
    step();
    step();
    rst = 1'b1;
    drive(1'b1, 17'd9, 1'b1, 1'b0);
    step();
    rst = 1'b0;
    checks++;
    if ((o_valid !== 1'b0) || (o_busy !== 1'b0)) begin
      errors++;
      $display("FAIL rstmid_state got valid=%b busy=%b want 0 0", o_valid, o_busy);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 17'd1, 1'b1, 1'b0);
      step();
      checks++;
      if (o_valid !== (i == 3)) begin
        errors++;
        $display("FAIL rstmid_valid step %0d got %b want %b", i, o_valid, (i == 3));
      end
    end
    checks++;
    if (o_data_bus !== 19'd4) begin
      errors++;
      $display("FAIL rstmid_total got %0d want 4", o_data_bus);
    end
    drive(1'b0, 17'd0, 1'b1, 1'b0);
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 17'd0, 1'b1, 1'b0);
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_flush();
    test_enable_freeze();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
